hdmi_in: RTL and testbench

Synthesizable video source for the `hdmi_clk` domain that produces the same `hdmi_vs` / `hdmi_de` / `hdmi_data` stream the PPM logging sink consumes.

- Generates complete raster timing (active, front porch, sync, back porch) plus a selectable test pattern.
- Used as the stimulus end of video-processing benches and as an on-board pattern source when no camera or HDMI input is attached.
- Sync polarity matches the Zybo convention: syncs are active-low.

---
 rtl/hdmi_in.sv | 172 +++++++++++++++++
 tb/tb_hdmi_in.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_in.sv
// -----------------------------------------------------------------------------
// hdmi_in
//
// Pattern video source for the pixel-clock domain. Generates a complete raster
// (active, front porch, sync, back porch) with active-low syncs and fills the
// active area with one of four test patterns. The stream has the same shape as
// the one the PPM logging sink consumes.
//
// Ports:
//   hdmi_clk     in   1   pixel clock (only clock)
//   rst          in   1   synchronous active-high reset
//   pattern_sel  in   2   0 colour bars, 1 gradient, 2 solid, 3 checkerboard
//   solid_rgb    in  24   {R,G,B} used by the solid pattern
//   hdmi_vs      out  1   vertical sync, active-low
//   hdmi_hs      out  1   horizontal sync, active-low
//   hdmi_de      out  1   data enable, high on active pixels
//   hdmi_data    out 32   {8'h00, R, G, B}; zero during blanking
//   sof          out  1   pulse with the first active pixel of each frame
//   frame_cnt    out  8   completed frames, wraps 255 -> 0
//
// All outputs are registered one cycle after the raster counters, so every
// output on a given cycle describes the same pixel position.
// -----------------------------------------------------------------------------
module hdmi_in #(
    parameter int horizontal_res = 640,
    parameter int vertical_res   = 480,
    parameter int h_front        = 16,
    parameter int h_sync         = 96,
    parameter int h_back         = 48,
    parameter int v_front        = 10,
    parameter int v_sync         = 2,
    parameter int v_back         = 33
) (
    input  logic        hdmi_clk,
    input  logic        rst,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic        hdmi_vs,
    output logic        hdmi_hs,
    output logic        hdmi_de,
    output logic [31:0] hdmi_data,
    output logic        sof,
    output logic [7:0]  frame_cnt
);

    localparam int H_TOTAL = horizontal_res + h_front + h_sync + h_back;
    localparam int V_TOTAL = vertical_res + v_front + v_sync + v_back;

    // Counters are a fixed 16 bits wide so the gradient can always take
    // x[7:0] / y[7:0] and the checkerboard bit 4, even on tiny rasters.
    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT    = 16'(horizontal_res);
    localparam logic [15:0] V_ACT    = 16'(vertical_res);
    localparam logic [15:0] HS_BEG   = 16'(horizontal_res + h_front);
    localparam logic [15:0] HS_END   = 16'(horizontal_res + h_front + h_sync);
    localparam logic [15:0] VS_BEG   = 16'(vertical_res + v_front);
    localparam logic [15:0] VS_END   = 16'(vertical_res + v_front + v_sync);
    localparam logic [15:0] BAR_LAST = 16'(horizontal_res / 8 - 1);

    logic [15:0] r_h_cnt;
    logic [15:0] r_v_cnt;
    logic [15:0] r_bar_pix;
    logic [2:0]  r_bar_idx;
    logic [1:0]  r_pat_sel;
    logic [23:0] r_solid;
    logic [7:0]  r_frame_cnt;
    logic        r_vs;
    logic        r_hs;
    logic        r_de;
    logic        r_sof;
    logic [31:0] r_data;

    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_eof;
    logic        w_active;
    logic        w_hs_n;
    logic        w_vs_n;
    logic        w_sof;
    logic [23:0] w_bar_rgb;
    logic [31:0] w_pix;

    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_v_wrap = (r_v_cnt == V_LAST);
    assign w_eof    = w_h_wrap && w_v_wrap;
    assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_n   = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
    // v_cnt only changes at h_cnt wrap, so vsync naturally spans whole lines.
    assign w_vs_n   = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
    assign w_sof    = (r_h_cnt == 16'd0) && (r_v_cnt == 16'd0);

    always_comb begin
        w_bar_rgb = 24'h000000;
        case (r_bar_idx)
            3'd0:    w_bar_rgb = 24'hFFFFFF;
            3'd1:    w_bar_rgb = 24'hFFFF00;
            3'd2:    w_bar_rgb = 24'h00FFFF;
            3'd3:    w_bar_rgb = 24'h00FF00;
            3'd4:    w_bar_rgb = 24'hFF00FF;
            3'd5:    w_bar_rgb = 24'hFF0000;
            3'd6:    w_bar_rgb = 24'h0000FF;
            default: w_bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        w_pix = 32'h0;
        case (r_pat_sel)
            2'd0:    w_pix = {8'h00, w_bar_rgb};
            2'd1:    w_pix = {8'h00, r_h_cnt[7:0], r_v_cnt[7:0], r_frame_cnt};
            2'd2:    w_pix = {8'h00, r_solid};
            default: w_pix = (r_h_cnt[4] ^ r_v_cnt[4]) ? 32'h00000000 : 32'h00FFFFFF;
        endcase
    end

    always_ff @(posedge hdmi_clk) begin
        if (rst) begin
            r_h_cnt     <= 16'd0;
            r_v_cnt     <= 16'd0;
            r_bar_pix   <= 16'd0;
            r_bar_idx   <= 3'd0;
            r_pat_sel   <= pattern_sel;
            r_solid     <= solid_rgb;
            r_frame_cnt <= 8'd0;
            r_vs        <= 1'b1;
            r_hs        <= 1'b1;
            r_de        <= 1'b0;
            r_sof       <= 1'b0;
            r_data      <= 32'h0;
        end else begin
            r_h_cnt <= w_h_wrap ? 16'd0 : r_h_cnt + 16'd1;
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? 16'd0 : r_v_cnt + 16'd1;
            end

            // Bar index tracks h_cnt with a width counter instead of a divide.
            // It keeps running through blanking and is realigned at line end.
            if (w_h_wrap) begin
                r_bar_pix <= 16'd0;
                r_bar_idx <= 3'd0;
            end else if (r_bar_pix == BAR_LAST) begin
                r_bar_pix <= 16'd0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_pix <= r_bar_pix + 16'd1;
            end

            // Pattern selection is only sampled between frames so a change
            // never tears the picture.
            if (w_eof) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_pat_sel   <= pattern_sel;
                r_solid     <= solid_rgb;
            end

            r_vs   <= w_vs_n;
            r_hs   <= w_hs_n;
            r_de   <= w_active;
            r_sof  <= w_sof;
            r_data <= w_active ? w_pix : 32'h0;
        end
    end

    assign hdmi_vs   = r_vs;
    assign hdmi_hs   = r_hs;
    assign hdmi_de   = r_de;
    assign hdmi_data = r_data;
    assign sof       = r_sof;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_hdmi_in.sv
// -----------------------------------------------------------------------------
// tb_hdmi_in
//
// Two instances of hdmi_in: a medium raster (48x20 active) for line, frame and
// pattern behaviour, and the 16x4 small raster for frame counter wrap and
// mid-line reset. Each instance has a reference model that derives the
// expected output purely from the number of cycles since reset release and
// the pattern that was selected at the last frame boundary.
// -----------------------------------------------------------------------------
module tb_hdmi_in;

    // medium raster
    localparam int MH = 48, MV = 20, MHF = 2, MHS = 4, MHB = 2, MVF = 1, MVS = 2, MVB = 2;
    localparam int MHT = MH + MHF + MHS + MHB;   // 56
    localparam int MVT = MV + MVF + MVS + MVB;   // 25
    localparam int MP  = MHT * MVT;              // 1400
    // small raster
    localparam int SH = 16, SV = 4, SHF = 1, SHS = 2, SHB = 1, SVF = 1, SVS = 1, SVB = 1;
    localparam int SHT = SH + SHF + SHS + SHB;   // 20
    localparam int SVT = SV + SVF + SVS + SVB;   // 7
    localparam int SP  = SHT * SVT;              // 140

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic        sof;
        logic [31:0] data;
        logic [7:0]  fc;
    } obs_t;

    localparam obs_t RST_OBS = '{vs: 1'b1, hs: 1'b1, de: 1'b0, sof: 1'b0, data: 32'h0, fc: 8'h0};
    localparam logic [31:0] BARS [8] = '{32'h00FFFFFF, 32'h00FFFF00, 32'h0000FFFF, 32'h0000FF00,
                                         32'h00FF00FF, 32'h00FF0000, 32'h000000FF, 32'h00000000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_m = 1'b1, rst_s = 1'b1;
    logic [1:0]  sel_m = 2'd0, sel_s = 2'd0;
    logic [23:0] rgb_m = 24'h0, rgb_s = 24'h0;
    logic        vs_m, hs_m, de_m, sof_m, vs_s, hs_s, de_s, sof_s;
    logic [31:0] data_m, data_s;
    logic [7:0]  fc_m, fc_s;
    obs_t        act_m, act_s;

    assign act_m = {vs_m, hs_m, de_m, sof_m, data_m, fc_m};
    assign act_s = {vs_s, hs_s, de_s, sof_s, data_s, fc_s};

    int vectors = 0;
    int miscompares = 0;

    hdmi_in #(
        .horizontal_res(MH), .vertical_res(MV), .h_front(MHF), .h_sync(MHS), .h_back(MHB),
        .v_front(MVF), .v_sync(MVS), .v_back(MVB)
    ) dut_m (
        .hdmi_clk(clk), .rst(rst_m), .pattern_sel(sel_m), .solid_rgb(rgb_m),
        .hdmi_vs(vs_m), .hdmi_hs(hs_m), .hdmi_de(de_m), .hdmi_data(data_m),
        .sof(sof_m), .frame_cnt(fc_m)
    );

    hdmi_in #(
        .horizontal_res(SH), .vertical_res(SV), .h_front(SHF), .h_sync(SHS), .h_back(SHB),
        .v_front(SVF), .v_sync(SVS), .v_back(SVB)
    ) dut_s (
        .hdmi_clk(clk), .rst(rst_s), .pattern_sel(sel_s), .solid_rgb(rgb_s),
        .hdmi_vs(vs_s), .hdmi_hs(hs_s), .hdmi_de(de_s), .hdmi_data(data_s),
        .sof(sof_s), .frame_cnt(fc_s)
    );

    // Expected output for the pixel shown t cycles after the first active
    // pixel of frame 0, with pattern pat in force for that frame.
    function automatic obs_t model(input int hres, vres, hf, hsw, vf, vsw, ht, vt, t,
                                   input logic [1:0] pat, input logic [23:0] rgb);
        obs_t o;
        int p, idx, x, y, frames;
        p      = ht * vt;
        idx    = t % p;
        x      = idx % ht;
        y      = idx / ht;
        frames = t / p;
        o.de   = (x < hres) && (y < vres);
        o.hs   = !((x >= hres + hf) && (x < hres + hf + hsw));
        o.vs   = !((y >= vres + vf) && (y < vres + vf + vsw));
        o.sof  = (idx == 0);
        o.fc   = 8'(((t + 1) / p) % 256);
        o.data = 32'h0;
        if (o.de) begin
            case (pat)
                2'd0:    o.data = BARS[x / (hres / 8)];
                2'd1:    o.data = {8'h00, 8'(x), 8'(y), 8'(frames)};
                2'd2:    o.data = {8'h00, rgb};
                default: o.data = ((((x / 16) + (y / 16)) % 2) == 1) ? 32'h0 : 32'h00FFFFFF;
            endcase
        end
        return o;
    endfunction

    // Reference state for the medium instance.
    int          t_m = -1;
    logic [1:0]  cur_sel_m = 2'd0, pend_sel_m = 2'd0;
    logic [23:0] cur_rgb_m = 24'h0, pend_rgb_m = 24'h0;
    obs_t        exp_m = RST_OBS;

    always @(posedge clk) begin : model_m
        int          nt;
        logic [1:0]  csel;
        logic [23:0] crgb;
        if (rst_m) begin
            t_m       <= -1;
            cur_sel_m <= sel_m;
            cur_rgb_m <= rgb_m;
            exp_m     <= RST_OBS;
        end else begin
            nt   = t_m + 1;
            csel = (nt > 0 && nt % MP == 0) ? pend_sel_m : cur_sel_m;
            crgb = (nt > 0 && nt % MP == 0) ? pend_rgb_m : cur_rgb_m;
            cur_sel_m <= csel;
            cur_rgb_m <= crgb;
            exp_m     <= model(MH, MV, MHF, MHS, MVF, MVS, MHT, MVT, nt, csel, crgb);
            if (nt % MP == MP - 1) begin
                pend_sel_m <= sel_m;
                pend_rgb_m <= rgb_m;
            end
            t_m <= nt;
        end
    end

    // Reference state for the small instance.
    int          t_s = -1;
    logic [1:0]  cur_sel_s = 2'd0, pend_sel_s = 2'd0;
    logic [23:0] cur_rgb_s = 24'h0, pend_rgb_s = 24'h0;
    obs_t        exp_s = RST_OBS;

    always @(posedge clk) begin : model_s
        int          nt;
        logic [1:0]  csel;
        logic [23:0] crgb;
        if (rst_s) begin
            t_s       <= -1;
            cur_sel_s <= sel_s;
            cur_rgb_s <= rgb_s;
            exp_s     <= RST_OBS;
        end else begin
            nt   = t_s + 1;
            csel = (nt > 0 && nt % SP == 0) ? pend_sel_s : cur_sel_s;
            crgb = (nt > 0 && nt % SP == 0) ? pend_rgb_s : cur_rgb_s;
            cur_sel_s <= csel;
            cur_rgb_s <= crgb;
            exp_s     <= model(SH, SV, SHF, SHS, SVF, SVS, SHT, SVT, nt, csel, crgb);
            if (nt % SP == SP - 1) begin
                pend_sel_s <= sel_s;
                pend_rgb_s <= rgb_s;
            end
            t_s <= nt;
        end
    end

    task automatic test_reset();
        rst_m = 1'b1; rst_s = 1'b1; sel_m = 2'd0; sel_s = 2'd0;
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if (act_m !== RST_OBS) begin
                miscompares++;
                $display("FAIL reset_m got=%h exp=%h", act_m, RST_OBS);
            end
            vectors++;
            if (act_s !== RST_OBS) begin
                miscompares++;
                $display("FAIL reset_s got=%h exp=%h", act_s, RST_OBS);
            end
        end
        rst_m = 1'b0; rst_s = 1'b0;
        @(negedge clk);
        vectors++;
        if ({de_m, sof_m, data_m} !== {1'b1, 1'b1, 32'h00FFFFFF}) begin
            miscompares++;
            $display("FAIL release_m de/sof/data got=%b/%b/%h exp=1/1/00ffffff", de_m, sof_m, data_m);
        end
        vectors++;
        if ({de_s, sof_s, data_s} !== {1'b1, 1'b1, 32'h00FFFFFF}) begin
            miscompares++;
            $display("FAIL release_s de/sof/data got=%b/%b/%h exp=1/1/00ffffff", de_s, sof_s, data_s);
        end
    endtask

    // Measures line 1 of the medium raster: de run, hsync width and position.
    task automatic test_line_timing();
        int de_cnt = 0, hs_low = 0, hs_first = -1;
        for (int k = 0; k < MHT && t_m != MHT - 1; k++) begin
            @(negedge clk);
            vectors++;
            if (act_m !== exp_m) begin
                miscompares++;
                $display("FAIL raster_m t=%0d got=%h exp=%h", t_m, act_m, exp_m);
            end
        end
        for (int k = 0; k < MHT; k++) begin
            @(negedge clk);
            vectors++;
            if (act_m !== exp_m) begin
                miscompares++;
                $display("FAIL raster_m t=%0d got=%h exp=%h", t_m, act_m, exp_m);
            end
            if (de_m) de_cnt++;
            if (!hs_m) begin
                hs_low++;
                if (hs_first < 0) hs_first = k;
            end
        end
        vectors++;
        if (de_cnt != MH) begin
            miscompares++;
            $display("FAIL line_de_len got=%0d exp=%0d", de_cnt, MH);
        end
        vectors++;
        if (hs_low != MHS) begin
            miscompares++;
            $display("FAIL line_hs_len got=%0d exp=%0d", hs_low, MHS);
        end
        vectors++;
        if (hs_first != MH + MHF) begin
            miscompares++;
            $display("FAIL line_hs_start got=%0d exp=%0d", hs_first, MH + MHF);
        end
    endtask

    // Runs the rest of frame 0 up to the second sof.
    task automatic test_frame_timing();
        int vs_first = -1, vs_low = 0, sof_at = -1;
        logic [7:0] fc_pre2 = 8'hxx, fc_pre1 = 8'hxx;
        for (int k = 0; k < MP && sof_at < 0; k++) begin
            @(negedge clk);
            vectors++;
            if (act_m !== exp_m) begin
                miscompares++;
                $display("FAIL raster_m t=%0d got=%h exp=%h", t_m, act_m, exp_m);
            end
            if (!vs_m) begin
                vs_low++;
                if (vs_first < 0) vs_first = t_m;
            end
            if (t_m == MP - 2) fc_pre2 = fc_m;
            if (t_m == MP - 1) fc_pre1 = fc_m;
            if (sof_m) sof_at = t_m;
        end
        vectors++;
        if (sof_at != MP) begin
            miscompares++;
            $display("FAIL sof_period got=%0d exp=%0d", sof_at, MP);
        end
        vectors++;
        if (vs_first != (MV + MVF) * MHT) begin
            miscompares++;
            $display("FAIL vs_start got=%0d exp=%0d", vs_first, (MV + MVF) * MHT);
        end
        vectors++;
        if (vs_low != MVS * MHT) begin
            miscompares++;
            $display("FAIL vs_len got=%0d exp=%0d", vs_low, MVS * MHT);
        end
        vectors++;
        if ({fc_pre2, fc_pre1} !== {8'd0, 8'd1}) begin
            miscompares++;
            $display("FAIL frame_cnt_step got=%0d,%0d exp=0,1", fc_pre2, fc_pre1);
        end
    endtask

    task automatic test_gradient();
        rst_m = 1'b1; sel_m = 2'd1;
        repeat (2) @(negedge clk);
        rst_m = 1'b0;
        for (int k = 0; k < 3 * MP; k++) begin
            @(negedge clk);
            vectors++;
            if (act_m !== exp_m) begin
                miscompares++;
                $display("FAIL raster_m t=%0d got=%h exp=%h", t_m, act_m, exp_m);
            end
            if (t_m == 2 * MP + 10 * MHT + 30) begin
                vectors++;
                if (data_m !== 32'h001E0A02) begin
                    miscompares++;
                    $display("FAIL gradient_px got=%h exp=001e0a02", data_m);
                end
            end
        end
    endtask

    task automatic test_pattern_switch();
        int solid_f0 = 0, solid_f1 = 0;
        rst_m = 1'b1; sel_m = 2'd0;
        repeat (2) @(negedge clk);
        rst_m = 1'b0;
        for (int k = 0; k < 2 * MP; k++) begin
            @(negedge clk);
            if (t_m == 10 * MHT) begin
                sel_m = 2'd2;
                rgb_m = 24'h123456;
            end
            vectors++;
            if (act_m !== exp_m) begin
                miscompares++;
                $display("FAIL raster_m t=%0d got=%h exp=%h", t_m, act_m, exp_m);
            end
            if (de_m && data_m == 32'h00123456) begin
                if (t_m < MP) solid_f0++;
                else solid_f1++;
            end
        end
        vectors++;
        if (solid_f0 != 0) begin
            miscompares++;
            $display("FAIL switch_tear got=%0d solid pixels exp=0", solid_f0);
        end
        vectors++;
        if (solid_f1 != MH * MV) begin
            miscompares++;
            $display("FAIL switch_next got=%0d solid pixels exp=%0d", solid_f1, MH * MV);
        end
    endtask

    task automatic test_random_patterns();
        sel_m = 2'd3;
        for (int k = 0; k < 4 * MP; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                sel_m = 2'($urandom_range(0, 3));
                rgb_m = 24'($urandom);
            end
            vectors++;
            if (act_m !== exp_m) begin
                miscompares++;
                $display("FAIL raster_m t=%0d got=%h exp=%h", t_m, act_m, exp_m);
            end
        end
    endtask

    task automatic test_wrap();
        int sofs = 0;
        logic [7:0] fc_a = 8'hxx, fc_b = 8'hxx;
        rst_s = 1'b1; sel_s = 2'd1;
        repeat (2) @(negedge clk);
        rst_s = 1'b0;
        for (int k = 0; k < 256 * SP + 1; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                sel_s = 2'($urandom_range(0, 3));
                rgb_s = 24'($urandom);
            end
            vectors++;
            if (act_s !== exp_s) begin
                miscompares++;
                $display("FAIL raster_s t=%0d got=%h exp=%h", t_s, act_s, exp_s);
            end
            if (sof_s) sofs++;
            if (t_s == 256 * SP - 2) fc_a = fc_s;
            if (t_s == 256 * SP - 1) fc_b = fc_s;
        end
        vectors++;
        if ({fc_a, fc_b} !== {8'd255, 8'd0}) begin
            miscompares++;
            $display("FAIL frame_cnt_wrap got=%0d,%0d exp=255,0", fc_a, fc_b);
        end
        vectors++;
        if (sofs != 257) begin
            miscompares++;
            $display("FAIL sof_count got=%0d exp=257", sofs);
        end
    endtask

    task automatic test_midline_reset();
        for (int k = 0; k < 2 * SP && t_s != 3 * SHT + 7; k++) @(negedge clk);
        rst_s = 1'b1;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (act_s !== RST_OBS) begin
                miscompares++;
                $display("FAIL midreset_hold got=%h exp=%h", act_s, RST_OBS);
            end
        end
        rst_s = 1'b0;
        @(negedge clk);
        vectors++;
        if ({de_s, sof_s, fc_s} !== {1'b1, 1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL midreset_restart de/sof/fc got=%b/%b/%0d exp=1/1/0", de_s, sof_s, fc_s);
        end
        for (int k = 0; k < 2 * SP; k++) begin
            @(negedge clk);
            vectors++;
            if (act_s !== exp_s) begin
                miscompares++;
                $display("FAIL raster_s t=%0d got=%h exp=%h", t_s, act_s, exp_s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_gradient();
        test_pattern_switch();
        test_random_patterns();
        test_wrap();
        test_midline_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
